// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared types and constants for the xadac decode channel
package xadac_pkg;

    localparam int SbLen = 16;
    localparam int IdW   = $clog2(SbLen);
    localparam int NoVs  = 3;

    typedef logic [IdW-1:0] IdT;

    localparam logic [2:0] F3_VLOAD  = 3'b000;
    localparam logic [2:0] F3_VSTORE = 3'b001;
    localparam logic [2:0] F3_VV     = 3'b010;
    localparam logic [2:0] F3_VVMAC  = 3'b011;
    localparam logic [2:0] F3_VX     = 3'b100;

    typedef struct packed {
        IdT              id;
        logic            accept;
        logic            vd_clobber;
        logic [NoVs-1:0] vs_read;
    } dec_rsp_t;

endpackage

// File: rtl/xadac_vdec_fifo.sv
// rtl/xadac_vdec_fifo.sv - in-order response FIFO with occupancy count
module xadac_vdec_fifo
    import xadac_pkg::*;
#(
    parameter int Depth = 4,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  dec_rsp_t        push_data,
    input  logic            pop,
    output dec_rsp_t        pop_data,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] occupancy
);

    localparam int PtrW = $clog2(Depth);

    dec_rsp_t        mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign full      = (count == CntW'(Depth));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign pop_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/xadac_vdec.sv
// rtl/xadac_vdec.sv - decode-stage responder classifying custom vector instructions
module xadac_vdec
    import xadac_pkg::*;
#(
    parameter int         Depth  = 4,
    parameter logic [6:0] Opcode = 7'b0001011,
    parameter int         CntW   = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dec_req_valid,
    output logic            dec_req_ready,
    input  logic [IdW-1:0]  dec_req_id,
    input  logic [31:0]     dec_req_instr,
    output logic            dec_rsp_valid,
    input  logic            dec_rsp_ready,
    output logic [IdW-1:0]  dec_rsp_id,
    output logic            dec_rsp_accept,
    output logic            dec_rsp_vd_clobber,
    output logic [NoVs-1:0] dec_rsp_vs_read,
    output logic [CntW-1:0] occupancy
);

    dec_rsp_t dec_d;
    dec_rsp_t head;
    logic     push;
    logic     pop;
    logic     full;
    logic     empty;

    // vs_read bit0=rs1 field, bit1=rs2 field, bit2=rd field read as a source.
    function automatic dec_rsp_t decode(input IdT id, input logic [31:0] instr);
        dec_rsp_t r;
        r    = '0;
        r.id = id;
        if (instr[6:0] == Opcode) begin
            case (instr[14:12])
                F3_VLOAD:  begin r.accept = 1'b1; r.vd_clobber = 1'b1; r.vs_read = 3'b000; end
                F3_VSTORE: begin r.accept = 1'b1; r.vd_clobber = 1'b0; r.vs_read = 3'b100; end
                F3_VV:     begin r.accept = 1'b1; r.vd_clobber = 1'b1; r.vs_read = 3'b011; end
                F3_VVMAC:  begin r.accept = 1'b1; r.vd_clobber = 1'b1; r.vs_read = 3'b111; end
                F3_VX:     begin r.accept = 1'b1; r.vd_clobber = 1'b1; r.vs_read = 3'b001; end
                default:   begin r.accept = 1'b0; r.vd_clobber = 1'b0; r.vs_read = 3'b000; end
            endcase
        end
        return r;
    endfunction

    assign dec_d         = decode(dec_req_id, dec_req_instr);
    assign dec_req_ready = !full;
    assign dec_rsp_valid = !empty;
    assign push          = dec_req_valid && dec_req_ready;
    assign pop           = dec_rsp_valid && dec_rsp_ready;

    xadac_vdec_fifo #(
        .Depth (Depth),
        .CntW  (CntW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (dec_d),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    assign dec_rsp_id         = head.id;
    assign dec_rsp_accept     = head.accept;
    assign dec_rsp_vd_clobber = head.vd_clobber;
    assign dec_rsp_vs_read    = head.vs_read;

endmodule

// File: tb/tb_xadac_vdec.sv
// tb/tb_xadac_vdec.sv - scoreboard bench for xadac_vdec
module tb_xadac_vdec;
    import xadac_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam logic [14:0] VS_TAB = {3'b001, 3'b111, 3'b011, 3'b100, 3'b000};

    logic            clk = 1'b0;
    logic            rstn;
    logic            dec_req_valid;
    logic            dec_req_ready;
    logic [IdW-1:0]  dec_req_id;
    logic [31:0]     dec_req_instr;
    logic            dec_rsp_valid;
    logic            dec_rsp_ready;
    logic [IdW-1:0]  dec_rsp_id;
    logic            dec_rsp_accept;
    logic            dec_rsp_vd_clobber;
    logic [NoVs-1:0] dec_rsp_vs_read;
    logic [CNTW-1:0] occupancy;

    int       n_vec = 0;
    int       n_err = 0;
    int       mcount = 0;
    dec_rsp_t sb[$];

    xadac_vdec #(.Depth(DEPTH), .Opcode(7'b0001011)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .dec_req_valid      (dec_req_valid),
        .dec_req_ready      (dec_req_ready),
        .dec_req_id         (dec_req_id),
        .dec_req_instr      (dec_req_instr),
        .dec_rsp_valid      (dec_rsp_valid),
        .dec_rsp_ready      (dec_rsp_ready),
        .dec_rsp_id         (dec_rsp_id),
        .dec_rsp_accept     (dec_rsp_accept),
        .dec_rsp_vd_clobber (dec_rsp_vd_clobber),
        .dec_rsp_vs_read    (dec_rsp_vs_read),
        .occupancy          (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic dec_rsp_t ref_decode(input logic [IdW-1:0] id, input logic [31:0] instr);
        dec_rsp_t r;
        int  f3;
        logic ok;
        f3           = int'(instr[14:12]);
        ok           = (instr[6:0] == 7'b0001011) && (f3 < 5);
        r.id         = id;
        r.accept     = ok;
        r.vd_clobber = ok && (f3 != 1);
        r.vs_read    = ok ? VS_TAB[f3*3 +: 3] : 3'b000;
        return r;
    endfunction

    // Monitor: occupancy model, handshake flags and in-order response check.
    always @(negedge clk) begin
        dec_rsp_t act;
        dec_rsp_t exp;
        if (!rstn) mcount = 0;
        chk("occupancy", 32'(occupancy), 32'(mcount));
        chk("req_ready", 32'(dec_req_ready), 32'(mcount != DEPTH));
        chk("rsp_valid", 32'(dec_rsp_valid), 32'(mcount != 0));
        act = '{id: dec_rsp_id, accept: dec_rsp_accept, vd_clobber: dec_rsp_vd_clobber,
                vs_read: dec_rsp_vs_read};
        if (!dec_rsp_valid) chk("idle_payload", 32'(act), 32'd0);
        if (rstn) begin
            if (dec_rsp_valid && dec_rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("stale_rsp", 32'(act), 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    chk("rsp_payload", 32'(act), 32'(exp));
                end
                mcount--;
            end
            if (dec_req_valid && dec_req_ready) mcount++;
            chk("fifo_bounds", 32'(mcount >= 0 && mcount <= DEPTH), 32'd1);
        end
    end

    task automatic send(input logic [IdW-1:0] id, input logic [31:0] instr);
        int t;
        t = 0;
        dec_req_valid = 1'b1;
        dec_req_id    = id;
        dec_req_instr = instr;
        forever begin
            @(negedge clk);
            if (dec_req_ready) break;
            t++;
            if (t > 200) break;
        end
        if (t > 200) chk("req_timeout", 32'd0, 32'd1);
        else sb.push_back(ref_decode(id, instr));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = 7'b0001011;
        return w;
    endfunction

    initial begin
        bit done;
        rstn          = 1'b1;
        dec_req_valid = 1'b0;
        dec_req_id    = '0;
        dec_req_instr = '0;
        dec_rsp_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_req_ready", 32'(dec_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(dec_rsp_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_payload", 32'({dec_rsp_id, dec_rsp_accept, dec_rsp_vd_clobber, dec_rsp_vs_read}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed decode cases.
        dec_rsp_ready = 1'b1;
        send(4'd2, 32'h0020A18B); idle();
        drain();
        send(4'd1, 32'h0002128B);
        send(4'd0, 32'h00000033); idle();
        drain();

        // Fill to full, stall a fifth request, then release in order.
        dec_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(IdW'(i), {17'h0, 3'(i), 5'd1, 7'b0001011});
        idle();
        repeat (3) @(negedge clk);
        chk("full_req_ready", 32'(dec_req_ready), 32'd0);
        chk("full_occupancy", 32'(occupancy), 32'd4);
        #1;
        fork
            send(4'd4, 32'h0000400B);
            begin
                repeat (4) @(posedge clk);
                #1 dec_rsp_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap.
        dec_rsp_ready = 1'b0;
        send(4'd10, rand_instr());
        send(4'd11, rand_instr());
        dec_rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(IdW'(i + 5), rand_instr());
        idle();
        drain();

        // Reset with three entries queued.
        dec_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(IdW'(i + 7), rand_instr());
        idle();
        #2 rstn = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(dec_rsp_valid), 32'd0);
        chk("midrst_occupancy", 32'(occupancy), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        dec_rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(IdW'($urandom), rand_instr());
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 dec_rsp_ready = ($urandom_range(0, 3) != 0);
                end
                dec_rsp_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xadac_vdec.md
Name: xadac_vdec

Overview:
- Decode-stage responder on the xadac dec channel. It sits directly downstream of the vector clobber-tracking stage on the dec_req/dec_rsp pair.
- Classifies each incoming custom instruction, queues the answer in an in-order response FIFO, and returns it on dec_rsp.
- The answer tells the clobber stage three things: whether the instruction is accepted, whether it writes vd, and which vector sources it reads.

Parameters:
- Depth, 4, response FIFO entries; power of two, >= 2.
- Opcode, 7'b0001011, major opcode accepted (custom-0).
- CntW, $clog2(Depth+1), occupancy counter width (derived).

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- dec_req_valid  in  1  request valid
- dec_req_ready  out  1  request ready
- dec_req_id  in  IdW  scoreboard id
- dec_req_instr  in  32  instruction word
- dec_rsp_valid  out  1  response valid
- dec_rsp_ready  in  1  response ready
- dec_rsp_id  out  IdW  id echoed from request
- dec_rsp_accept  out  1  instruction accepted
- dec_rsp_vd_clobber  out  1  instruction writes vd (instr[11:7])
- dec_rsp_vs_read  out  NoVs  bit0=instr[19:15], bit1=instr[24:20], bit2=instr[11:7] read as vector source
- occupancy  out  CntW  entries currently held

Behaviour:
- Reset: clk/rstn as decided: reset rstn, asynchronous, active-low; clock clk. rstn low clears wr_ptr, rd_ptr and count asynchronously. Entry storage need not be reset.
- Outputs during/after reset: dec_req_ready=1, dec_rsp_valid=0, occupancy=0, all dec_rsp payload fields 0.
- Decode (combinational on dec_req_instr, captured at push):
  - If opcode != Opcode: accept=0, clobber=0, vs_read=000.
  - Otherwise, by funct3=instr[14:12]:
    - 000 VLOAD: accept=1, clobber=1, vs_read=000.
    - 001 VSTORE: accept=1, clobber=0, vs_read=100.
    - 010 VV op: accept=1, clobber=1, vs_read=011.
    - 011 VV MAC: accept=1, clobber=1, vs_read=111.
    - 100 VX op: accept=1, clobber=1, vs_read=001.
    - 101..111: accept=0, clobber=0, vs_read=000.
  - Rejected responses always carry clobber=0 and vs_read=0.
- Push: dec_req_valid && dec_req_ready. dec_req_ready = (count != Depth). No ready dependency on dec_rsp_ready; a full FIFO blocks even when a pop occurs in the same cycle.
- Pop: dec_rsp_valid && dec_rsp_ready. dec_rsp_valid = (count != 0).
- Payload when empty is forced to 0. When non-empty, payload is the entry at rd_ptr.
- Latency: a request pushed at edge N is visible on dec_rsp at N+1 at the earliest. There is no same-cycle bypass.
- Ordering: strict FIFO; responses are returned in acceptance order regardless of id.
- Pointers are log2(Depth) bits and wrap naturally modulo Depth. count tracks occupancy and equals occupancy.
- Simultaneous push and pop (only possible when 0 < count < Depth): both pointers advance, count unchanged.
- Pop when empty or push when full cannot occur, since valid/ready gate them. Bench asserts the FIFO never overflows or underflows.
- dec_rsp payload is held stable while dec_rsp_valid && !dec_rsp_ready.
- Reset mid-operation drops all queued entries. No response is emitted for dropped entries.

Decomposition:
- xadac_pkg holds:
  - IdT / IdW, NoVs, SbLen.
  - Funct3 constants: F3_VLOAD, F3_VSTORE, F3_VV, F3_VVMAC, F3_VX.
  - Packed dec_rsp_t {id, accept, vd_clobber, vs_read}.
- Sub-module xadac_vdec_fifo: generic dec_rsp_t FIFO (Depth, push/pop, occupancy).
- The top level keeps the decode function and handshake glue.

Test Plan:
- Reset then idle: dec_req_ready=1, dec_rsp_valid=0, occupancy=0, payload 0.
- Push id=2, instr=0x0020A18B (VV, rd3, rs1=1, rs2=2) with dec_rsp_ready=1 -> next cycle dec_rsp_valid=1, id=2, accept=1, clobber=1, vs_read=011; occupancy 1 then 0.
- Push id=1, instr=0x0002128B (VSTORE) -> accept=1, clobber=0, vs_read=100. Push id=0, instr=0x00000033 -> accept=0, clobber=0, vs_read=000.
- Hold dec_rsp_ready=0 and push 4 requests ids 0..3 -> dec_req_ready=0 and occupancy=4. A 5th request stalls. Release ready -> ids pop in order 0,1,2,3 with stable payloads.
- At occupancy 2, drive push and pop in the same cycle for 6 cycles -> occupancy stays 2 and the pointers wrap; the response sequence matches push order.
- Fill 3 entries, then assert rstn low mid-stream -> immediately dec_rsp_valid=0 and occupancy=0. After release, no stale responses appear.
